// File: rtl/icache_pkg.sv
// Local types and helpers for the N-way instruction cache.
package icache_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_AR,
    ST_R,
    ST_FILL
  } icache_state_t;

  // Way-index width; a direct-mapped cache still carries a 1-bit way index.
  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction
endpackage

// File: rtl/riscv_defines_pkg.sv
// AXI encodings shared by the instruction and data caches.
package riscv_defines_pkg;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
endpackage

// File: rtl/icache_nway_if.sv
// Fetch-side request/response plus AXI AR/R channel bundle for icache_nway.
interface icache_nway_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pc_addr;
  logic              pc_valid;
  logic              flush;
  logic [31:0]       instruction;
  logic              instr_valid;
  logic              instr_err;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    input  pc_addr, pc_valid, flush, arready, rvalid, rdata, rresp, rlast,
    output instruction, instr_valid, instr_err, arvalid, araddr, arlen, arsize, arburst, rready
  );
  modport slave (
    output pc_addr, pc_valid, flush, arready, rvalid, rdata, rresp, rlast,
    input  instruction, instr_valid, instr_err, arvalid, araddr, arlen, arsize, arburst, rready
  );
endinterface

// File: rtl/icache_refill_axi.sv
// AXI burst engine: AR/R handshakes, in-order line buffer and sticky error flag for one refill.
module icache_refill_axi
  import riscv_defines_pkg::*;
#(
  parameter int BEATS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               ar_phase_i,
  input  logic               r_phase_i,
  input  logic               arready_i,
  input  logic               rvalid_i,
  input  logic [31:0]        rdata_i,
  input  logic [1:0]         rresp_i,
  input  logic               rlast_i,
  output logic               arvalid_o,
  output logic               rready_o,
  output logic               ar_done_o,
  output logic               r_done_o,
  output logic [BEATS*32-1:0] line_o,
  output logic               err_o
);
  localparam int BEAT_W = $clog2(BEATS);

  logic [BEAT_W-1:0] beat_q;
  logic              err_q;
  logic [31:0]       line_buf_q [BEATS];
  logic              beat_fire;

  assign arvalid_o = ar_phase_i;
  assign rready_o  = r_phase_i;
  assign ar_done_o = ar_phase_i && arready_i;
  assign beat_fire = r_phase_i && rvalid_i;
  assign r_done_o  = beat_fire && rlast_i;
  assign err_o     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      err_q  <= 1'b0;
    end else if (start_i) begin
      beat_q <= '0;
      err_q  <= 1'b0;
    end else if (beat_fire) begin
      beat_q <= rlast_i ? '0 : beat_q + 1'b1;
      if (rresp_i != AXI_RESP_OKAY) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_fire) line_buf_q[beat_q] <= rdata_i;
  end

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_line
    assign line_o[gi*32 +: 32] = line_buf_q[gi];
  end
endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with per-set round-robin refill over AXI.
// Define ICACHE_PERF_CNT_EN to add saturating hit_cnt/miss_cnt outputs.
module icache_nway
  import icache_pkg::*;
  import riscv_defines_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 16,
  parameter int LINE_BYTES = 32,
  parameter int ADDR_W     = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  icache_nway_if.master bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
`endif
);
  localparam int BEATS  = LINE_BYTES / 4;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WORD_W = $clog2(BEATS);
  localparam int WAY_W  = way_bits(WAYS);
  localparam int LINE_W = BEATS * 32;

  icache_state_t     state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q;
  logic              flush_pend_q;
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAY_W-1:0]  rr_q [SETS];

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx, pc_idx;
  logic [WORD_W-1:0] req_word;
  logic [WAYS-1:0]   hit_vec;
  logic [LINE_W-1:0] way_line [WAYS];
  logic [WAY_W-1:0]  hit_way, victim;
  logic              found_invalid;
  logic [LINE_W-1:0] hit_line, refill_line;
  logic              accept, lookup_hit, lookup_miss, install;
  logic              ar_done, r_done, refill_err;
  logic              unused_addr_bits;

  assign req_tag          = req_addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx          = req_addr_q[OFF_W +: IDX_W];
  assign req_word         = req_addr_q[2 +: WORD_W];
  assign pc_idx           = bus.pc_addr[OFF_W +: IDX_W];
  assign unused_addr_bits = ^req_addr_q[1:0];

  assign accept      = (state_q == ST_IDLE) && bus.pc_valid;
  assign lookup_hit  = (state_q == ST_LOOKUP) && (|hit_vec) && !bus.flush;
  assign lookup_miss = (state_q == ST_LOOKUP) && !lookup_hit;
  // A flush seen anywhere during this refill, or in the install cycle itself, keeps the line out.
  assign install     = (state_q == ST_FILL) && !refill_err && !flush_pend_q && !bus.flush;

  // Tag/data RAMs are read when the fetch is accepted so lookup sees them one cycle later.
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic [TAG_W-1:0]  tag_mem [SETS];
    logic [LINE_W-1:0] data_mem [SETS];
    logic [TAG_W-1:0]  tag_rd_q;
    logic [LINE_W-1:0] data_rd_q;

    always_ff @(posedge clk) begin
      if (install && (victim == WAY_W'(gi))) begin
        tag_mem[req_idx]  <= req_tag;
        data_mem[req_idx] <= refill_line;
      end
      if (accept) begin
        tag_rd_q  <= tag_mem[pc_idx];
        data_rd_q <= data_mem[pc_idx];
      end
    end

    assign hit_vec[gi]  = valid_q[req_idx][gi] && (tag_rd_q == req_tag);
    assign way_line[gi] = data_rd_q;
  end

  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end
  assign hit_line = way_line[hit_way];

  always_comb begin
    victim        = rr_q[req_idx];
    found_invalid = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_invalid && !valid_q[req_idx][w]) begin
        victim        = WAY_W'(w);
        found_invalid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.pc_valid) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = lookup_hit ? ST_IDLE : ST_AR;
      ST_AR:     if (ar_done) state_d = ST_R;
      ST_R:      if (r_done) state_d = ST_FILL;
      ST_FILL:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.instr_valid = 1'b0;
    bus.instr_err   = 1'b0;
    bus.instruction = '0;
    if (lookup_hit) begin
      bus.instr_valid = 1'b1;
      bus.instruction = hit_line[{req_word, 5'd0} +: 32];
    end else if (state_q == ST_FILL) begin
      bus.instr_valid = 1'b1;
      bus.instr_err   = refill_err;
      bus.instruction = refill_err ? 32'd0 : refill_line[{req_word, 5'd0} +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_addr_q   <= '0;
      flush_pend_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) req_addr_q <= bus.pc_addr;
      if (bus.flush && (state_q != ST_IDLE)) flush_pend_q <= 1'b1;
      else if (accept)                       flush_pend_q <= 1'b0;
      if (bus.flush) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (install) begin
        valid_q[req_idx][victim] <= 1'b1;
      end
      if (install) begin
        rr_q[req_idx] <= (rr_q[req_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[req_idx] + 1'b1;
      end
    end
  end

  assign bus.araddr  = {req_addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign bus.arlen   = 8'(BEATS - 1);
  assign bus.arsize  = AXI_SIZE_4B;
  assign bus.arburst = AXI_BURST_INCR;

  icache_refill_axi #(.BEATS(BEATS)) u_refill (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (lookup_miss),
    .ar_phase_i (state_q == ST_AR),
    .r_phase_i  (state_q == ST_R),
    .arready_i  (bus.arready),
    .rvalid_i   (bus.rvalid),
    .rdata_i    (bus.rdata),
    .rresp_i    (bus.rresp),
    .rlast_i    (bus.rlast),
    .arvalid_o  (bus.arvalid),
    .rready_o   (bus.rready),
    .ar_done_o  (ar_done),
    .r_done_o   (r_done),
    .line_o     (refill_line),
    .err_o      (refill_err)
  );

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (lookup_hit && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (lookup_miss && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule
